// File: rtl/shift_reg_seq.sv
// shift_reg_seq: command sequencer for a 4-bit shift/rotate/load register.
//
// A host hands over one command at a time on a valid/ready handshake. The
// sequencer latches the register controls, then holds o_enb high for the
// commanded number of cycles and pulses o_done when it finishes.
//
// Optional feature macro: SHIFT_REG_SEQ_QUEUE_EN
//   When defined, a one-entry command buffer lets the next command start
//   with no idle cycle between commands.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_cmd_valid         command present
//   o_cmd_ready         command can be accepted
//   i_cmd_op            00 shift, 01 rotate, 10 load, 11 illegal
//   i_cmd_dir           0 left, 1 right
//   i_cmd_steps         shift/rotate cycle count
//   i_cmd_data          parallel load value
//   i_cmd_sin           serial fill bit
//   o_enb, o_modo, o_dir, o_d, o_s_in   register controls
//   o_busy              command executing
//   o_done, o_err       one-cycle completion / illegal-op pulses
//   o_steps_left        remaining enable cycles, including the current one
module shift_reg_seq #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic             i_cmd_dir,
    input  logic [CNT_W-1:0] i_cmd_steps,
    input  logic [3:0]       i_cmd_data,
    input  logic             i_cmd_sin,
    output logic             o_enb,
    output logic [1:0]       o_modo,
    output logic             o_dir,
    output logic [3:0]       o_d,
    output logic             o_s_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_steps_left
);

    localparam logic [1:0] OpLoad    = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_steps_left;
    logic [1:0]       r_modo;
    logic             r_dir;
    logic [3:0]       r_d;
    logic             r_s_in;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_last;
    // Command being started at this edge, from the ports or the buffer.
    logic             w_launch;
    logic [1:0]       w_l_op;
    logic             w_l_dir;
    logic [CNT_W-1:0] w_l_steps;
    logic [3:0]       w_l_data;
    logic             w_l_sin;

    assign w_accept = i_cmd_valid & o_cmd_ready;
    assign w_last   = (r_state == StRun) && (r_steps_left == CNT_W'(1));

`ifdef SHIFT_REG_SEQ_QUEUE_EN
    logic             r_q_valid;
    logic [1:0]       r_q_op;
    logic             r_q_dir;
    logic [CNT_W-1:0] r_q_steps;
    logic [3:0]       r_q_data;
    logic             r_q_sin;
    logic             w_q_runnable;
    logic             w_from_q;
    logic             w_store;

    assign o_cmd_ready  = ~r_q_valid;
    assign w_store      = w_accept && (r_state == StRun);
    // Only commands that produce ENB cycles can chain without a bubble; a
    // zero-step or illegal entry retires from IDLE so its DONE gets its own slot.
    assign w_q_runnable = (r_q_op == OpLoad) ||
                          ((r_q_op != OpIllegal) && (r_q_steps != '0));

    always_comb begin
        w_launch  = 1'b0;
        w_from_q  = 1'b0;
        w_l_op    = i_cmd_op;
        w_l_dir   = i_cmd_dir;
        w_l_steps = i_cmd_steps;
        w_l_data  = i_cmd_data;
        w_l_sin   = i_cmd_sin;
        if (r_state == StIdle) begin
            if (r_q_valid) begin
                w_from_q = 1'b1;
                w_launch = 1'b1;
            end else if (w_accept) begin
                w_launch = 1'b1;
            end
        end else if (w_last && r_q_valid && w_q_runnable) begin
            w_from_q = 1'b1;
            w_launch = 1'b1;
        end
        if (w_from_q) begin
            w_l_op    = r_q_op;
            w_l_dir   = r_q_dir;
            w_l_steps = r_q_steps;
            w_l_data  = r_q_data;
            w_l_sin   = r_q_sin;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q_valid <= 1'b0;
            r_q_op    <= 2'b00;
            r_q_dir   <= 1'b0;
            r_q_steps <= '0;
            r_q_data  <= 4'b0000;
            r_q_sin   <= 1'b0;
        end else if (w_store) begin
            r_q_valid <= 1'b1;
            r_q_op    <= i_cmd_op;
            r_q_dir   <= i_cmd_dir;
            r_q_steps <= i_cmd_steps;
            r_q_data  <= i_cmd_data;
            r_q_sin   <= i_cmd_sin;
        end else if (w_from_q) begin
            r_q_valid <= 1'b0;
        end
    end
`else
    assign o_cmd_ready = (r_state == StIdle);

    always_comb begin
        w_launch  = w_accept;
        w_l_op    = i_cmd_op;
        w_l_dir   = i_cmd_dir;
        w_l_steps = i_cmd_steps;
        w_l_data  = i_cmd_data;
        w_l_sin   = i_cmd_sin;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_steps_left <= '0;
            r_modo       <= 2'b00;
            r_dir        <= 1'b0;
            r_d          <= 4'b0000;
            r_s_in       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == StRun) begin
                r_steps_left <= r_steps_left - CNT_W'(1);
                if (w_last) begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                end
            end
            // A launch at the final RUN edge overrides the return to IDLE.
            if (w_launch) begin
                if (w_l_op == OpIllegal) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end else begin
                    r_modo <= w_l_op;
                    r_dir  <= w_l_dir;
                    r_d    <= w_l_data;
                    r_s_in <= w_l_sin;
                    if (w_l_op == OpLoad) begin
                        r_state      <= StRun;
                        r_steps_left <= CNT_W'(1);
                    end else if (w_l_steps != '0) begin
                        r_state      <= StRun;
                        r_steps_left <= w_l_steps;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_enb        = (r_state == StRun);
    assign o_busy       = (r_state == StRun);
    assign o_modo       = r_modo;
    assign o_dir        = r_dir;
    assign o_d          = r_d;
    assign o_s_in       = r_s_in;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_steps_left = r_steps_left;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq with a command-level reference model
// and an external 4-bit register driven by the sequencer's controls.
module tb_shift_reg_seq;

    localparam int CNT_W = 4;
`ifdef SHIFT_REG_SEQ_QUEUE_EN
    localparam logic QUEUE = 1'b1;
`else
    localparam logic QUEUE = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [3:0]       cmd_data;
    logic             cmd_sin;
    logic             enb;
    logic [1:0]       modo;
    logic             dir;
    logic [3:0]       d;
    logic             s_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] steps_left;

    int n_checks;
    int n_errors;

    // Expected register controls (last accepted legal command).
    logic [1:0] m_modo;
    logic       m_dir;
    logic [3:0] m_d;
    logic       m_sin;

    // The register the sequencer drives.
    logic [3:0] reg_q;

    shift_reg_seq #(.CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_dir    (cmd_dir),
        .i_cmd_steps  (cmd_steps),
        .i_cmd_data   (cmd_data),
        .i_cmd_sin    (cmd_sin),
        .o_enb        (enb),
        .o_modo       (modo),
        .o_dir        (dir),
        .o_d          (d),
        .o_s_in       (s_in),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b00:   reg_q <= dir ? {s_in, reg_q[3:1]} : {reg_q[2:0], s_in};
                2'b01:   reg_q <= dir ? {reg_q[0], reg_q[3:1]} : {reg_q[2:0], reg_q[3]};
                2'b10:   reg_q <= d;
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_ctrl();
        check_val("modo", 32'(modo), 32'(m_modo));
        check_val("dir", 32'(dir), 32'(m_dir));
        check_val("d", 32'(d), 32'(m_d));
        check_val("s_in", 32'(s_in), 32'(m_sin));
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge of
    // the DONE cycle so a following call is accepted back-to-back.
    task automatic run_cmd(input logic [1:0] op, input logic dr, input logic [CNT_W-1:0] st,
                           input logic [3:0] data, input logic sin);
        int   n;
        logic e_err;
        check_val("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_dir   = dr;
        cmd_steps = st;
        cmd_data  = data;
        cmd_sin   = sin;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (op == 2'b11) begin
            n     = 0;
            e_err = 1'b1;
        end else begin
            e_err  = 1'b0;
            n      = (op == 2'b10) ? 1 : int'(st);
            m_modo = op;
            m_dir  = dr;
            m_d    = data;
            m_sin  = sin;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_val("enb_run", 32'(enb), 32'd1);
            check_val("busy_run", 32'(busy), 32'd1);
            check_val("steps_left", 32'(steps_left), 32'(n - k));
            check_val("done_run", 32'(done), 32'd0);
            check_val("err_run", 32'(err), 32'd0);
            check_val("ready_run", 32'(cmd_ready), 32'(QUEUE));
            check_ctrl();
        end
        @(negedge clk);
        check_val("enb_done", 32'(enb), 32'd0);
        check_val("busy_done", 32'(busy), 32'd0);
        check_val("done", 32'(done), 32'd1);
        check_val("err", 32'(err), 32'(e_err));
        check_val("steps_done", 32'(steps_left), 32'd0);
        check_val("ready_done", 32'(cmd_ready), 32'd1);
        check_ctrl();
    endtask

    initial begin
        int v;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        cmd_data  = 4'h0;
        cmd_sin   = 1'b0;
        m_modo    = 2'b00;
        m_dir     = 1'b0;
        m_d       = 4'h0;
        m_sin     = 1'b0;
        reg_q     = 4'h0;

        // Reset values
        #2;
        check_val("rst_enb", 32'(enb), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_steps", 32'(steps_left), 32'd0);
        check_ctrl();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Load 1010, then rotate right 3
        run_cmd(2'b10, 1'b0, 4'd0, 4'b1010, 1'b0);
        check_val("reg_load", 32'(reg_q), 32'hA);
        @(negedge clk);
        run_cmd(2'b01, 1'b1, 4'd3, 4'b1010, 1'b0);
        v = 10;
        v = ((v >> 3) | (v << 1)) & 15;
        check_val("reg_rotr3", 32'(reg_q), 32'(v));

        // Zero-step shift and illegal op
        @(negedge clk);
        run_cmd(2'b00, 1'b0, 4'd0, 4'h5, 1'b1);
        @(negedge clk);
        run_cmd(2'b11, 1'b1, 4'd7, 4'hF, 1'b1);
        @(negedge clk);

        // Back-to-back shift-left x2, two steps each
        if (!QUEUE) begin
            run_cmd(2'b00, 1'b0, 4'd2, 4'h3, 1'b1);
            run_cmd(2'b00, 1'b0, 4'd2, 4'h6, 1'b0);
        end else begin
            cmd_op = 2'b00; cmd_dir = 1'b0; cmd_steps = 4'd2; cmd_data = 4'h3; cmd_sin = 1'b1;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            m_modo = 2'b00; m_dir = 1'b0; m_d = 4'h3; m_sin = 1'b1;
            @(negedge clk);
            check_val("q_enb1", 32'(enb), 32'd1);
            check_val("q_ready1", 32'(cmd_ready), 32'd1);
            cmd_data = 4'h6; cmd_sin = 1'b0;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    m_d   = 4'h6;
                    m_sin = 1'b0;
                end
                check_val("q_enb", 32'(enb), (c < 3) ? 32'd1 : 32'd0);
                check_val("q_done", 32'(done), (c == 1 || c == 3) ? 32'd1 : 32'd0);
                check_ctrl();
            end
        end
        @(negedge clk);

        // Reset during the 2nd of 5 ENB cycles
        cmd_op = 2'b00; cmd_dir = 1'b1; cmd_steps = 4'd5; cmd_data = 4'h9; cmd_sin = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check_val("mid_enb1", 32'(enb), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_enb", 32'(enb), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_steps", 32'(steps_left), 32'd0);
        m_modo = 2'b00; m_dir = 1'b0; m_d = 4'h0; m_sin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("post_rst_done", 32'(done), 32'd0);
            check_val("post_rst_enb", 32'(enb), 32'd0);
            check_val("post_rst_ready", 32'(cmd_ready), 32'd1);
        end

        // Random commands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            int gap;
            run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    CNT_W'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_val("gap_done", 32'(done), 32'd0);
                check_val("gap_enb", 32'(enb), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Command sequencer for the 4-bit shift/rotate/load register.
- Accepts one command at a time over a valid/ready handshake and drives the register's ENB, MODO, DIR, D and S_IN controls.
- Asserts ENB for exactly the commanded number of cycles, then pulses DONE.
- Sits between a host/bus-side controller and a single register instance, so software-level operations ("rotate right 3", "load 0xA") need no cycle-level control.

## Interface
Parameters:
- CNT_W, default 4: width of the step count; maximum steps per command is 2^CNT_W-1.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous and active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  2  operation: 00 shift, 01 rotate, 10 parallel load, 11 illegal.
- CMD_DIR  in  1  0 left, 1 right; ignored for load.
- CMD_STEPS  in  CNT_W  number of shift/rotate cycles; ignored for load.
- CMD_DATA  in  4  parallel load value.
- CMD_SIN  in  1  serial fill bit for shift.
- ENB  out  1  register enable.
- MODO  out  2  register mode; equals the accepted CMD_OP, except that 11 is never driven.
- DIR  out  1  register direction.
- D  out  4  register parallel data.
- S_IN  out  1  register serial input.
- BUSY  out  1  a command is executing.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse for an illegal op.
- STEPS_LEFT  out  CNT_W  remaining enable cycles, including the current one.

## Operation
- States: IDLE and RUN.
- Accept: a command is accepted on a CLK edge where CMD_VALID=1 and CMD_READY=1.
- Control capture: on accept, MODO, DIR, D and S_IN are registered from the command. They hold until the next accepted legal command.
- Shift/rotate with CMD_STEPS=N>0: go to RUN with STEPS_LEFT=N. In RUN, ENB=1 and STEPS_LEFT decrements each edge. On the edge where STEPS_LEFT=1, return to IDLE.
- Load: go to RUN with STEPS_LEFT=1, so there is exactly one ENB cycle.
- Shift/rotate with N=0: no RUN and no ENB; DONE pulses the next cycle.
- Illegal op (11): accepted, control outputs unchanged, no ENB; DONE and ERR pulse together the next cycle.
- BUSY=1 exactly when in RUN. ENB=BUSY.
- CMD_READY (macro absent) = IDLE.

## Timing
- Reset values: ENB 0, MODO 00, DIR 0, D 0000, S_IN 0, BUSY 0, DONE 0, ERR 0, STEPS_LEFT 0. State is IDLE, so CMD_READY=1 once out of reset.
- Latency: for a command accepted at edge t, ENB is high in cycles t+1 through t+N. DONE is high in cycle t+N+1.
- Back-to-back (macro absent): CMD_READY is high in the DONE cycle. A command accepted at that edge starts ENB in the following cycle, giving exactly one idle cycle between commands.
- Controls are stable before ENB rises and throughout the ENB window; they never change while BUSY=1.
- Reset mid-operation: ENB, BUSY and STEPS_LEFT drop immediately (asynchronously). No DONE is issued for the aborted command.
- CMD_VALID with CMD_READY=0: the command is not accepted. The host must hold its fields stable until acceptance.

## Configuration
- SHIFT_REG_SEQ_QUEUE_EN defined:
  - Adds a one-entry command buffer; CMD_READY = buffer empty, independent of state.
  - A command accepted while in RUN is stored.
  - On the final ENB cycle of the current command, the stored command's controls load at the same edge that ends the current command, and execution continues with no idle bubble. ENB stays high across the boundary.
  - DONE pulses once per command in its normal slot; pulses for adjacent commands may be consecutive cycles.
  - A stored zero-step or illegal command retires with its DONE (and ERR for illegal) the cycle after the preceding command's DONE.
  - Reset clears the buffer.
- Not defined: no buffer; behaviour as described above.

## Test plan
- Load: op=10, data=1010 accepted -> MODO=10, D=1010, ENB high exactly 1 cycle, DONE one cycle later, BUSY low after.
- Rotate right 3: op=01, dir=1, steps=3 -> ENB high 3 cycles, STEPS_LEFT 3,2,1; DONE the next cycle; register 1010 -> 0101 -> 1010 -> 0101.
- Zero/illegal: steps=0 shift -> no ENB, DONE next cycle; op=11 -> no ENB, DONE+ERR next cycle, MODO unchanged.
- Reset mid-run: RST asserted during the 2nd of 5 ENB cycles -> ENB and BUSY 0 immediately, no DONE, CMD_READY=1 after release.
- Back-to-back: two shift-left commands of 2 steps each -> macro absent: ENB 2 on, 1 off, 2 on; macro defined: ENB high 4 consecutive cycles, with two DONE pulses.
